post_spike_aer_encoder: RTL and testbench
=========================================

// Module: post_spike_aer_encoder
// PURPOSE
//  Downstream of the IF neuron core. Captures each post-synaptic spike (spike_out + neuron index) during a time step.
//  Buffers spikes in a FIFO and emits them as AER words over a valid/ready interface.
//  Appends an end-of-step (EOS) marker word carrying the step index after the last neuron of each step.
//  Keeps per-step spike, drop and overflow status for the FF/STDP controller.
// PARAMETERS
//  AER_WIDTH        12  neuron address width; also the width of the EOS step-index field
//  FIFO_DEPTH       16  entries, power of 2, >=4
//  STEP_CNT_WIDTH   8   step index counter width, wraps
//  DROP_CNT_WIDTH   8   dropped-spike counter width, saturates
// PORTS
//  CLK             in   1              clock
//  RST             in   1              reset: asynchronous, active-high
//  spike_in        in   1              spike_out of IF neuron, valid for one cycle
//  spike_addr      in   AER_WIDTH      index of the neuron currently evaluated
//  time_step_done  in   1              pulse: last neuron of the step has been evaluated
//  time_ref_event  in   1              pulse: reference-window reset (same event fed to the neuron)
//  aer_out_data    out  AER_WIDTH+1    [AER_WIDTH]=EOS flag; low bits = neuron addr or step index
//  aer_out_valid   out  1              word available
//  aer_out_ready   in   1              consumer accepts the word when valid&ready
//  step_spike_cnt  out  AER_WIDTH+1    spikes accepted in the current step
//  drop_cnt        out  DROP_CNT_WIDTH saturating count of dropped spikes
//  overflow        out  1              sticky: any spike or EOS dropped
//  fifo_level      out  log2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty. Step index 0.
//  Spike push
//   - spike_in=1 with free>=2: push {0,spike_addr}; step_spike_cnt +1.
//   - Otherwise drop: drop_cnt +1 (saturating at all-ones); overflow<=1.
//   - The last slot is always reserved for EOS.
//  EOS push
//   - time_step_done=1 with free>=1: push {1,step_idx}; step_idx +1 (wraps).
//   - The step_spike_cnt value shown for the closing step is visible that cycle; it clears to 0 next cycle.
//   - If free==0: EOS dropped, overflow<=1; step_idx still increments.
//  Simultaneous spike_in and time_step_done: write both entries in one cycle, spike first, EOS second.
//   - The spike is counted in the closing step.
//  Simultaneous push and pop: both take effect; level = level + pushes - pop.
//  Read side
//   - Show-ahead FIFO. A word pushed at cycle N into an empty FIFO has valid=1 at N+1.
//   - While valid & !ready, data and valid are held stable.
//   - A pop occurs only on valid&ready.
//  Throughput: one pop per cycle sustained. FIFO_DEPTH consecutive pushes without pops fill the FIFO (free-slot rules above).
//  time_ref_event
//   - Clears step_idx, step_spike_cnt, drop_cnt and overflow next cycle.
//   - FIFO contents are NOT flushed.
//   - If it coincides with time_step_done, the EOS is pushed with the old step_idx, then step_idx is cleared to 0.
//   - If it coincides with spike_in, the spike is pushed; step_spike_cnt is 0 after the cycle.
//  Async RST mid-operation: FIFO pointers and all counters clear immediately; aer_out_valid drops to 0 asynchronously.
//  Pointers: log2(DEPTH)+1 bits with a wrap bit. full/empty are derived from pointer comparison. No X on data when empty (output 0).
// STRUCTURE
//  Shared include snn_ff_defs.vh:
//   - AER_EOS_BIT position.
//   - Word-type localparams (AER_T_SPIKE=0, AER_T_EOS=1).
//  Sub-module aer_sync_fifo:
//   - Dual-write (0/1/2 pushes per cycle), single-read, show-ahead.
//   - Exposes level/free.
//  Top module: push arbitration, counters, status.
// TESTING
//  1. Reset, then spikes at addr 3,7,9 and time_step_done, ready=1 -> words 0x003,0x007,0x009, then EOS {1,0}; step_spike_cnt=3 before clearing.
//  2. ready=0, 20 spikes with DEPTH=16 -> 15 accepted; drop_cnt=5; overflow=1; EOS still accepted -> level=16.
//  3. spike_in (addr 5) and time_step_done in the same cycle -> 0x005 then EOS; both written in one cycle (level +2).
//  4. Toggle ready randomly during a burst -> data held stable while valid&!ready; order preserved; no duplicates.
//  5. time_ref_event with the FIFO holding 4 words and drop_cnt=3 -> counters/overflow cleared; 4 words still drain; next EOS index=0.
//  6. Assert RST during a burst -> valid=0 immediately; level=0; first spike after reset appears one cycle later.

Source files
------------

// File: rtl/post_spike_aer_encoder_pkg.sv
// Shared definitions for the post-synaptic spike AER encoder: word-type tags,
// default widths and the EOS word builder.
package post_spike_aer_encoder_pkg;

  typedef enum logic {
    AER_T_SPIKE = 1'b0,
    AER_T_EOS   = 1'b1
  } aer_type_e;

  localparam int AER_WIDTH_DEF      = 12;
  localparam int FIFO_DEPTH_DEF     = 16;
  localparam int STEP_CNT_WIDTH_DEF = 8;
  localparam int DROP_CNT_WIDTH_DEF = 8;

  // The EOS flag sits directly above the address field.
  localparam int AER_EOS_BIT = AER_WIDTH_DEF;

endpackage

// File: rtl/post_spike_aer_encoder_aer_sync_fifo.sv
// Show-ahead synchronous FIFO with up to two writes and one read per cycle.
// Pointers carry a wrap bit so full and empty fall out of a plain subtraction.
module post_spike_aer_encoder_aer_sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_a,
  input  logic [WIDTH-1:0]         data_a,
  input  logic                     push_b,
  input  logic [WIDTH-1:0]         data_b,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   free
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [PW:0]      wr_ptr_b;

  assign level    = wr_ptr - rd_ptr;
  assign free     = (PW+1)'(DEPTH) - level;
  assign rd_valid = (wr_ptr != rd_ptr);
  // Empty reads return zero so stale or uninitialised storage never leaks out.
  assign rd_data  = rd_valid ? mem[rd_ptr[PW-1:0]] : '0;
  assign wr_ptr_b = wr_ptr + (PW+1)'(push_a);

  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr[PW-1:0]] <= data_a;
    if (push_b) mem[wr_ptr_b[PW-1:0]] <= data_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (PW+1)'(push_a) + (PW+1)'(push_b);
      rd_ptr <= rd_ptr + (PW+1)'(pop && rd_valid);
    end
  end

endmodule

// File: rtl/post_spike_aer_encoder.sv
// Captures IF-neuron output spikes, queues them as AER words with an end-of-step
// marker per time step, and keeps per-step spike/drop/overflow status.
module post_spike_aer_encoder
  import post_spike_aer_encoder_pkg::*;
#(
  parameter int AER_WIDTH      = AER_WIDTH_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int STEP_CNT_WIDTH = STEP_CNT_WIDTH_DEF,
  parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        spike_in,
  input  logic [AER_WIDTH-1:0]        spike_addr,
  input  logic                        time_step_done,
  input  logic                        time_ref_event,
  output logic [AER_WIDTH:0]          aer_out_data,
  output logic                        aer_out_valid,
  input  logic                        aer_out_ready,
  output logic [AER_WIDTH:0]          step_spike_cnt,
  output logic [DROP_CNT_WIDTH-1:0]   drop_cnt,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [LW-1:0]             free;
  logic [STEP_CNT_WIDTH-1:0] step_idx;
  logic                      spike_ok;
  logic                      eos_ok;
  logic [AER_WIDTH:0]        spike_word;
  logic [AER_WIDTH:0]        eos_word;
  logic                      push_a;
  logic                      push_b;
  logic [AER_WIDTH:0]        data_a;

  // A spike needs two free slots so the last one always stays open for EOS.
  assign spike_ok   = spike_in && (free >= LW'(2));
  assign eos_ok     = time_step_done && (free > LW'(spike_ok));
  assign spike_word = {1'(AER_T_SPIKE), spike_addr};
  assign eos_word   = {1'(AER_T_EOS), AER_WIDTH'(step_idx)};

  // Spike goes first when both are written in the same cycle.
  assign push_a = spike_ok || eos_ok;
  assign push_b = spike_ok && eos_ok;
  assign data_a = spike_ok ? spike_word : eos_word;

  post_spike_aer_encoder_aer_sync_fifo #(
    .WIDTH (AER_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push_a   (push_a),
    .data_a   (data_a),
    .push_b   (push_b),
    .data_b   (eos_word),
    .pop      (aer_out_ready),
    .rd_data  (aer_out_data),
    .rd_valid (aer_out_valid),
    .level    (fifo_level),
    .free     (free)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step_idx       <= '0;
      step_spike_cnt <= '0;
      drop_cnt       <= '0;
      overflow       <= 1'b0;
    end else if (time_ref_event) begin
      step_idx       <= '0;
      step_spike_cnt <= '0;
      drop_cnt       <= '0;
      overflow       <= 1'b0;
    end else begin
      if (time_step_done) begin
        step_idx       <= step_idx + STEP_CNT_WIDTH'(1);
        step_spike_cnt <= '0;
      end else if (spike_ok) begin
        step_spike_cnt <= step_spike_cnt + (AER_WIDTH+1)'(1);
      end
      if (spike_in && !spike_ok && (drop_cnt != '1))
        drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      if ((spike_in && !spike_ok) || (time_step_done && !eos_ok))
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_post_spike_aer_encoder.sv
// Directed bench for post_spike_aer_encoder: stimulus queues the expected AER
// words, an independent monitor pops and compares them as the DUT offers them.
module tb_post_spike_aer_encoder;
  logic        CLK = 1'b0;
  logic        RST;
  logic        spike_in;
  logic [11:0] spike_addr;
  logic        time_step_done;
  logic        time_ref_event;
  logic [12:0] aer_out_data;
  logic        aer_out_valid;
  logic        aer_out_ready;
  logic [12:0] step_spike_cnt;
  logic [7:0]  drop_cnt;
  logic        overflow;
  logic [4:0]  fifo_level;

  logic [12:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  post_spike_aer_encoder dut (
    .CLK            (CLK),
    .RST            (RST),
    .spike_in       (spike_in),
    .spike_addr     (spike_addr),
    .time_step_done (time_step_done),
    .time_ref_event (time_ref_event),
    .aer_out_data   (aer_out_data),
    .aer_out_valid  (aer_out_valid),
    .aer_out_ready  (aer_out_ready),
    .step_spike_cnt (step_spike_cnt),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: front of the queue must be on the bus whenever valid is high.
  always @(negedge CLK) begin
    if (RST !== 1'b1 && aer_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got 0x%0h expected none at %0t", aer_out_data, $time);
      end else begin
        check("aer_word", 32'(aer_out_data), 32'(exp_q[0]));
        if (aer_out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic s, input logic [11:0] a, input logic d, input logic r);
    spike_in       = s;
    spike_addr     = a;
    time_step_done = d;
    time_ref_event = r;
    tick();
    spike_in       = 1'b0;
    time_step_done = 1'b0;
    time_ref_event = 1'b0;
  endtask

  task automatic drain();
    aer_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !aer_out_valid) break;
      tick();
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(aer_out_valid), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    spike_in = 1'b0;
    spike_addr = '0;
    time_step_done = 1'b0;
    time_ref_event = 1'b0;
    aer_out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", 32'(aer_out_valid), 32'd0);
    check("rst_data", 32'(aer_out_data), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_spk", 32'(step_spike_cnt), 32'd0);
    RST = 1'b0;
    tick();

    // 1: three spikes then EOS for step 0
    aer_out_ready = 1'b1;
    exp_q.push_back(13'h003); drive(1'b1, 12'd3, 1'b0, 1'b0);
    exp_q.push_back(13'h007); drive(1'b1, 12'd7, 1'b0, 1'b0);
    exp_q.push_back(13'h009); drive(1'b1, 12'd9, 1'b0, 1'b0);
    time_step_done = 1'b1;
    check("t1_spk_before", 32'(step_spike_cnt), 32'd3);
    exp_q.push_back(13'h1000);
    tick();
    time_step_done = 1'b0;
    check("t1_spk_after", 32'(step_spike_cnt), 32'd0);
    drain();

    // 2: fill with ready low, last slot reserved for EOS
    aer_out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 15) exp_q.push_back(13'(12'h100 + 12'(i)));
      drive(1'b1, 12'h100 + 12'(i), 1'b0, 1'b0);
    end
    check("t2_level", 32'(fifo_level), 32'd15);
    check("t2_drop", 32'(drop_cnt), 32'd5);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_spk", 32'(step_spike_cnt), 32'd15);
    exp_q.push_back(13'h1001);
    drive(1'b0, 12'd0, 1'b1, 1'b0);
    check("t2_level_eos", 32'(fifo_level), 32'd16);
    drain();
    check("t2_ovf_sticky", 32'(overflow), 32'd1);

    // 3: spike and EOS in the same cycle
    aer_out_ready = 1'b0;
    exp_q.push_back(13'h005);
    exp_q.push_back(13'h1002);
    drive(1'b1, 12'd5, 1'b1, 1'b0);
    check("t3_level", 32'(fifo_level), 32'd2);
    check("t3_spk", 32'(step_spike_cnt), 32'd0);
    drain();

    // 4: random backpressure during a burst
    for (int i = 0; i < 10; i++) begin
      aer_out_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(13'(12'h020 + 12'(i)));
      drive(1'b1, 12'h020 + 12'(i), 1'b0, 1'b0);
    end
    exp_q.push_back(13'h1003);
    drive(1'b0, 12'd0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      aer_out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // 5: reference event with words still queued
    drive(1'b0, 12'd0, 1'b0, 1'b1);
    check("t5_drop_clr0", 32'(drop_cnt), 32'd0);
    check("t5_ovf_clr0", 32'(overflow), 32'd0);
    exp_q.push_back(13'h1000);
    drive(1'b0, 12'd0, 1'b1, 1'b0);
    drain();
    aer_out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 15) exp_q.push_back(13'(12'h040 + 12'(i)));
      drive(1'b1, 12'h040 + 12'(i), 1'b0, 1'b0);
    end
    check("t5_drop", 32'(drop_cnt), 32'd3);
    check("t5_ovf", 32'(overflow), 32'd1);
    aer_out_ready = 1'b1;
    repeat (11) tick();
    aer_out_ready = 1'b0;
    check("t5_level4", 32'(fifo_level), 32'd4);
    drive(1'b0, 12'd0, 1'b0, 1'b1);
    check("t5_drop_clr", 32'(drop_cnt), 32'd0);
    check("t5_ovf_clr", 32'(overflow), 32'd0);
    check("t5_spk_clr", 32'(step_spike_cnt), 32'd0);
    check("t5_level_kept", 32'(fifo_level), 32'd4);
    exp_q.push_back(13'h1000);
    drive(1'b0, 12'd0, 1'b1, 1'b0);
    drain();

    // 6: asynchronous reset mid-burst
    aer_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(13'(12'h060 + 12'(i)));
      drive(1'b1, 12'h060 + 12'(i), 1'b0, 1'b0);
    end
    spike_in = 1'b1;
    spike_addr = 12'h066;
    #2;
    RST = 1'b1;
    exp_q.delete();
    #1;
    check("t6_valid_async", 32'(aer_out_valid), 32'd0);
    check("t6_level_async", 32'(fifo_level), 32'd0);
    check("t6_data_async", 32'(aer_out_data), 32'd0);
    spike_in = 1'b0;
    tick();
    RST = 1'b0;
    exp_q.push_back(13'h0AB);
    spike_in = 1'b1;
    spike_addr = 12'h0AB;
    check("t6_valid_pre", 32'(aer_out_valid), 32'd0);
    tick();
    spike_in = 1'b0;
    check("t6_valid_post", 32'(aer_out_valid), 32'd1);
    check("t6_data_post", 32'(aer_out_data), 32'h0AB);
    drain();

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
